// File: rtl/sp_core_pkg.sv
// Shared encodings for the sp_core two-stage pipe: ALU opcodes, writeback
// source select and the stage-2 state type.
package sp_core_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_EQ  = 4'd8;
    localparam logic [3:0] ALU_CID = 4'd9;
    localparam logic [3:0] ALU_NCR = 4'd10;

    localparam logic [1:0] S2_IMM   = 2'd0;
    localparam logic [1:0] S2_LOAD  = 2'd1;
    localparam logic [1:0] S2_ALU   = 2'd2;
    localparam logic [1:0] S2_STORE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2
    } s2_state_t;

endpackage

// File: rtl/sp_regfile.sv
// Register file: two combinational read ports, one write port, write-first
// bypass so a read of the address being written returns the new data.
module sp_regfile #(
    parameter  int DATA_W = 16,
    parameter  int REG_N  = 16,
    localparam int RA_W   = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [RA_W-1:0]   i_wa,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [RA_W-1:0]   i_ra_a,
    input  logic [RA_W-1:0]   i_ra_b,
    output logic [DATA_W-1:0] o_rd_a,
    output logic [DATA_W-1:0] o_rd_b
);

    logic [DATA_W-1:0] r_mem [REG_N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd_a = (i_we && (i_wa == i_ra_a)) ? i_wd : r_mem[i_ra_a];
    assign o_rd_b = (i_we && (i_wa == i_ra_b)) ? i_wd : r_mem[i_ra_b];

endmodule

// File: rtl/sp_core_pipe.sv
// Two-stage issue/execute core with a simple load/store handshake.
// Define SP_CORE_FWD_EN to forward the stage-2 ALU/IMM result instead of stalling.
module sp_core_pipe
    import sp_core_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int REG_N   = 16,
    parameter  int CORE_ID = 0,
    parameter  int N_CORES = 1,
    localparam int RA_W    = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [RA_W-1:0]   x,
    input  logic [RA_W-1:0]   y,
    input  logic [RA_W-1:0]   z,
    input  logic [DATA_W-1:0] imm,
    input  logic [3:0]        aluc,
    input  logic [1:0]        s2,
    input  logic              reg_we,
    output logic              P,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    localparam int SH_W = $clog2(DATA_W);

    // state     | meaning
    // IDLE      | stage 2 empty
    // EXEC      | stage 2 holds an instruction, executes on next enabled edge
    // MEM_WAIT  | load/store request outstanding, waiting for mem_ack
    s2_state_t         r_state;
    logic [DATA_W-1:0] r_a, r_b, r_imm;
    logic [3:0]        r_aluc;
    logic [1:0]        r_s2;
    logic [RA_W-1:0]   r_x;
    logic              r_we;
    logic              r_p;
    logic              r_live;
    logic              r_ack_sticky;
    logic [DATA_W-1:0] r_rdata_hold;
    logic              r_mem_req, r_mem_we;
    logic [DATA_W-1:0] r_mem_addr, r_mem_wdata;

    logic [DATA_W-1:0] w_rd_a, w_rd_b, w_alu, w_wd, w_ld_data;
    logic              w_s2_mem, w_ack, w_ld_done, w_s2_wr, w_rf_we;
    logic              w_hazard, w_stall, w_xfer;

    assign w_s2_mem  = (r_s2 == S2_LOAD) || (r_s2 == S2_STORE);
    assign w_ack     = mem_ack || r_ack_sticky;
    assign w_ld_data = r_ack_sticky ? r_rdata_hold : mem_rdata;
    assign w_ld_done = en && (r_state == ST_MEM_WAIT) && w_ack && (r_s2 == S2_LOAD) && r_we;
    assign w_s2_wr   = en && (r_state == ST_EXEC) && !w_s2_mem && r_we;
    assign w_rf_we   = w_s2_wr || w_ld_done;
    assign w_wd      = (r_state == ST_MEM_WAIT) ? w_ld_data :
                       ((r_s2 == S2_IMM) ? r_imm : w_alu);

    // With forwarding the regfile write-first bypass already delivers the
    // stage-2 result to the S1 read, so the hazard never needs a stall.
`ifdef SP_CORE_FWD_EN
    assign w_hazard = 1'b0;
`else
    assign w_hazard = (r_state == ST_EXEC) && !w_s2_mem && r_we && ((y == r_x) || (z == r_x));
`endif

    assign w_stall     = (r_state == ST_MEM_WAIT) || ((r_state == ST_EXEC) && w_s2_mem) || w_hazard;
    assign issue_ready = r_live && en && !w_stall;
    assign w_xfer      = issue_valid && issue_ready;

    sp_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (reset),
        .i_we   (w_rf_we),
        .i_wa   (r_x),
        .i_wd   (w_wd),
        .i_ra_a (y),
        .i_ra_b (z),
        .o_rd_a (w_rd_a),
        .o_rd_b (w_rd_b)
    );

    always_comb begin
        w_alu = '0;
        case (r_aluc)
            ALU_ADD: w_alu = r_a + r_b;
            ALU_SUB: w_alu = r_a - r_b;
            ALU_AND: w_alu = r_a & r_b;
            ALU_OR:  w_alu = r_a | r_b;
            ALU_XOR: w_alu = r_a ^ r_b;
            ALU_SHL: w_alu = r_a << r_b[SH_W-1:0];
            ALU_SHR: w_alu = r_a >> r_b[SH_W-1:0];
            ALU_SLT: w_alu = DATA_W'(r_a < r_b);
            ALU_EQ:  w_alu = DATA_W'(r_a == r_b);
            ALU_CID: w_alu = DATA_W'(CORE_ID);
            ALU_NCR: w_alu = DATA_W'(N_CORES);
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_imm        <= '0;
            r_aluc       <= '0;
            r_s2         <= '0;
            r_x          <= '0;
            r_we         <= 1'b0;
            r_p          <= 1'b0;
            r_live       <= 1'b0;
            r_ack_sticky <= 1'b0;
            r_rdata_hold <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_live <= 1'b1;
            if (!en) begin
                // An ack while frozen is remembered, data included, for re-enable.
                if ((r_state == ST_MEM_WAIT) && mem_ack) begin
                    r_ack_sticky <= 1'b1;
                    r_rdata_hold <= mem_rdata;
                end
            end else begin
                if (w_xfer) begin
                    r_a    <= w_rd_a;
                    r_b    <= w_rd_b;
                    r_imm  <= imm;
                    r_aluc <= aluc;
                    r_s2   <= s2;
                    r_x    <= x;
                    r_we   <= reg_we;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (w_xfer) r_state <= ST_EXEC;
                    end
                    ST_EXEC: begin
                        if (w_s2_mem) begin
                            r_state     <= ST_MEM_WAIT;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= (r_s2 == S2_STORE);
                            r_mem_addr  <= r_b;
                            r_mem_wdata <= r_a;
                        end else begin
                            if ((r_s2 == S2_ALU) && ((r_aluc == ALU_SLT) || (r_aluc == ALU_EQ)))
                                r_p <= w_alu[0];
                            r_state <= w_xfer ? ST_EXEC : ST_IDLE;
                        end
                    end
                    ST_MEM_WAIT: begin
                        if (w_ack) begin
                            r_mem_req    <= 1'b0;
                            r_ack_sticky <= 1'b0;
                            r_state      <= w_xfer ? ST_EXEC : ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign P         = r_p;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != ST_IDLE);

endmodule
